seven_seg_monitor: RTL and testbench

- Receive-side counterpart of seven_seg_controller: watches the multiplexed, active-low segment/anode bus and reconstructs the 16-bit hex value and decimal points being shown.
- Used in self-checking benches and on-chip loopback. It taps seg/an in parallel with the physical display and reports each complete 4-digit frame, pattern errors and a stalled scan.

---
 rtl/seven_seg_pkg.sv | 49 ++++
 rtl/seven_seg_pattern_decode.sv | 43 ++++
 rtl/seven_seg_monitor.sv | 177 +++++++++++++++++
 tb/tb_seven_seg_monitor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions for the display encoder and the bus monitor.
// Holds the active-low bus convention, the bit position of each segment on the
// bus, and the gfedcba (active-high) pattern for every hex glyph plus blank.
package seven_seg_pkg;

    // Both segment and anode lines are driven low to light / select.
    localparam logic ACTIVE_LOW = 1'b1;

    // Bit positions on the segment bus.
    localparam int SEG_A_BIT  = 0;
    localparam int SEG_B_BIT  = 1;
    localparam int SEG_C_BIT  = 2;
    localparam int SEG_D_BIT  = 3;
    localparam int SEG_E_BIT  = 4;
    localparam int SEG_F_BIT  = 5;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    // Active-high gfedcba glyph patterns.
    localparam logic [6:0] SEG_PAT_0     = 7'h3F;
    localparam logic [6:0] SEG_PAT_1     = 7'h06;
    localparam logic [6:0] SEG_PAT_2     = 7'h5B;
    localparam logic [6:0] SEG_PAT_3     = 7'h4F;
    localparam logic [6:0] SEG_PAT_4     = 7'h66;
    localparam logic [6:0] SEG_PAT_5     = 7'h6D;
    localparam logic [6:0] SEG_PAT_6     = 7'h7D;
    localparam logic [6:0] SEG_PAT_7     = 7'h07;
    localparam logic [6:0] SEG_PAT_8     = 7'h7F;
    localparam logic [6:0] SEG_PAT_9     = 7'h6F;
    localparam logic [6:0] SEG_PAT_A     = 7'h77;
    localparam logic [6:0] SEG_PAT_B     = 7'h7C;
    localparam logic [6:0] SEG_PAT_C     = 7'h39;
    localparam logic [6:0] SEG_PAT_D     = 7'h5E;
    localparam logic [6:0] SEG_PAT_E     = 7'h79;
    localparam logic [6:0] SEG_PAT_F     = 7'h71;
    localparam logic [6:0] SEG_PAT_BLANK = 7'h00;

    // Convert a raw segment bus byte into active-high form (1 = lit).
    function automatic logic [7:0] seg_to_active_high(input logic [7:0] bus);
        logic [7:0] lit;
        if (ACTIVE_LOW) begin
            lit = ~bus;
        end else begin
            lit = bus;
        end
        return lit;
    endfunction

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Combinational glyph decoder.
// Ports:
//   pattern  - active-high gfedcba segment pattern
//   nibble   - hex value of the glyph (0 for blank or unrecognised patterns)
//   is_blank - all segments off
//   is_valid - pattern is a hex glyph or blank
module seven_seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       is_blank,
    output logic       is_valid
);

    // Map each legal glyph back to its hex value.
    always_comb begin
        nibble   = 4'h0;
        is_blank = 1'b0;
        is_valid = 1'b1;
        case (pattern)
            SEG_PAT_0:     nibble = 4'h0;
            SEG_PAT_1:     nibble = 4'h1;
            SEG_PAT_2:     nibble = 4'h2;
            SEG_PAT_3:     nibble = 4'h3;
            SEG_PAT_4:     nibble = 4'h4;
            SEG_PAT_5:     nibble = 4'h5;
            SEG_PAT_6:     nibble = 4'h6;
            SEG_PAT_7:     nibble = 4'h7;
            SEG_PAT_8:     nibble = 4'h8;
            SEG_PAT_9:     nibble = 4'h9;
            SEG_PAT_A:     nibble = 4'hA;
            SEG_PAT_B:     nibble = 4'hB;
            SEG_PAT_C:     nibble = 4'hC;
            SEG_PAT_D:     nibble = 4'hD;
            SEG_PAT_E:     nibble = 4'hE;
            SEG_PAT_F:     nibble = 4'hF;
            SEG_PAT_BLANK: is_blank = 1'b1;
            default:       is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_monitor.sv
// Receive-side monitor for a multiplexed active-low seven-segment display.
// Reconstructs the 4-digit hex value, decimal points and blank digits being
// scanned, flags undecodable glyphs and reports a stalled scan.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   segments[7:0]   - active-low segment bus ([6:0]=g..a, [7]=dp)
//   anodes[3:0]     - active-low digit selects, anodes[i] -> digit i
//   digits[15:0]    - last complete frame, nibble i = digit i
//   decimal_points  - dp lit per digit of last frame
//   blank           - digit was all-off in last frame (nibble reads 0)
//   frame_valid     - one-cycle pulse when the frame outputs update
//   pattern_error   - one-cycle pulse on capture of an undecodable glyph
//   stalled         - no valid capture for TIMEOUT_CYCLES cycles
module seven_seg_monitor
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  segments,
    input  logic [3:0]  anodes,
    output logic [15:0] digits,
    output logic [3:0]  decimal_points,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        pattern_error,
    output logic        stalled
);

    localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYCLES);

    logic [11:0]      sample_r;
    logic [CNT_W-1:0] settle_cnt_r;
    logic             capture_done_r;
    logic [15:0]      shadow_digits_r;
    logic [3:0]       shadow_dp_r;
    logic [3:0]       shadow_blank_r;
    logic [3:0]       mask_r;
    logic [TO_W-1:0]  timeout_r;

    logic [7:0]       seg_high_s;
    logic             dp_lit_s;
    logic [3:0]       nibble_s;
    logic             is_blank_s;
    logic             is_valid_s;
    logic             one_hot_s;
    logic [1:0]       dig_idx_s;
    logic [3:0]       dig_sel_s;
    logic             capture_s;
    logic             good_s;
    logic             bad_s;
    logic [3:0]       mask_set_s;
    logic [15:0]      shadow_digits_s;
    logic [3:0]       shadow_dp_s;
    logic [3:0]       shadow_blank_s;
    logic [TO_W-1:0]  timeout_inc_s;

    seven_seg_pattern_decode u_decode (
        .pattern  (seg_high_s[SEG_G_BIT:SEG_A_BIT]),
        .nibble   (nibble_s),
        .is_blank (is_blank_s),
        .is_valid (is_valid_s)
    );

    // Capture qualification and the shadow contents a capture would produce.
    always_comb begin
        seg_high_s = seg_to_active_high(sample_r[7:0]);
        dp_lit_s   = seg_high_s[SEG_DP_BIT];
        dig_sel_s  = ~sample_r[11:8];
        one_hot_s  = 1'b1;
        dig_idx_s  = 2'd0;
        case (sample_r[11:8])
            4'b1110: dig_idx_s = 2'd0;
            4'b1101: dig_idx_s = 2'd1;
            4'b1011: dig_idx_s = 2'd2;
            4'b0111: dig_idx_s = 2'd3;
            default: one_hot_s = 1'b0;
        endcase
        capture_s  = (settle_cnt_r == SETTLE_MAX) && !capture_done_r && one_hot_s;
        good_s     = capture_s && is_valid_s;
        bad_s      = capture_s && !is_valid_s;
        mask_set_s = mask_r | dig_sel_s;

        shadow_digits_s = shadow_digits_r;
        shadow_dp_s     = shadow_dp_r;
        shadow_blank_s  = shadow_blank_r;
        shadow_digits_s[{dig_idx_s, 2'b00} +: 4] = nibble_s;
        shadow_dp_s[dig_idx_s]    = dp_lit_s;
        shadow_blank_s[dig_idx_s] = is_blank_s;

        if (timeout_r == TO_MAX) begin
            timeout_inc_s = timeout_r;
        end else begin
            timeout_inc_s = timeout_r + TO_W'(1);
        end
    end

    // Input sample register, settle counter and one-capture-per-dwell flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_r       <= 12'h000;
            settle_cnt_r   <= '0;
            capture_done_r <= 1'b0;
        end else begin
            sample_r <= {anodes, segments};
            if ({anodes, segments} != sample_r) begin
                settle_cnt_r   <= '0;
                capture_done_r <= 1'b0;
            end else begin
                if (settle_cnt_r != SETTLE_MAX) begin
                    settle_cnt_r <= settle_cnt_r + CNT_W'(1);
                end else begin
                    settle_cnt_r <= settle_cnt_r;
                end
                capture_done_r <= capture_done_r | capture_s;
            end
        end
    end

    // Frame assembly: shadow writes, completion mask and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_digits_r <= 16'h0000;
            shadow_dp_r     <= 4'h0;
            shadow_blank_r  <= 4'h0;
            mask_r          <= 4'h0;
            digits          <= 16'h0000;
            decimal_points  <= 4'h0;
            blank           <= 4'h0;
            frame_valid     <= 1'b0;
            pattern_error   <= 1'b0;
        end else begin
            frame_valid   <= 1'b0;
            pattern_error <= bad_s;
            if (good_s) begin
                shadow_digits_r <= shadow_digits_s;
                shadow_dp_r     <= shadow_dp_s;
                shadow_blank_r  <= shadow_blank_s;
                if (mask_set_s == 4'b1111) begin
                    // Final digit goes straight to the outputs with the rest.
                    digits         <= shadow_digits_s;
                    decimal_points <= shadow_dp_s;
                    blank          <= shadow_blank_s;
                    frame_valid    <= 1'b1;
                    mask_r         <= 4'b0000;
                end else begin
                    mask_r <= mask_set_s;
                end
            end else if (bad_s) begin
                // Digit must be recaptured cleanly before the frame can close.
                mask_r <= mask_r & ~dig_sel_s;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Stall detector; a valid capture always wins over saturation.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_r <= '0;
            stalled   <= 1'b0;
        end else if (good_s) begin
            timeout_r <= '0;
            stalled   <= 1'b0;
        end else begin
            timeout_r <= timeout_inc_s;
            stalled   <= (timeout_inc_s == TO_MAX);
        end
    end

endmodule

// File: tb/tb_seven_seg_monitor.sv
// Directed bench for seven_seg_monitor (SETTLE_CYCLES=4, TIMEOUT_CYCLES=64).
// Inputs change 1 time unit after a rising edge and outputs are sampled there.
module tb_seven_seg_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  segments;
    logic [3:0]  anodes;
    logic [15:0] digits;
    logic [3:0]  decimal_points;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        pattern_error;
    logic        stalled;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int pe_cnt = 0;

    seven_seg_monitor #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .segments       (segments),
        .anodes         (anodes),
        .digits         (digits),
        .decimal_points (decimal_points),
        .blank          (blank),
        .frame_valid    (frame_valid),
        .pattern_error  (pattern_error),
        .stalled        (stalled)
    );

    always #5 clk = ~clk;

    // Pulse counters for frame_valid and pattern_error.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (pattern_error === 1'b1) pe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        anodes   = an;
        segments = seg;
        step(n);
    endtask

    // One 16-cycle dwell of digit idx showing active-high pattern pat.
    task automatic show(input int idx, input logic [6:0] pat, input logic dp);
        logic [3:0] an;
        an = ~(4'b0001 << idx);
        hold(an, ~{dp, pat}, 16);
    endtask

    initial begin
        reset    = 1'b1;
        anodes   = 4'hF;
        segments = 8'hFF;
        step(3);
        chk("rst_digits", digits, 16'h0000);
        chk("rst_dp", decimal_points, 4'h0);
        chk("rst_blank", blank, 4'h0);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_pe", pattern_error, 1'b0);
        chk("rst_stalled", stalled, 1'b0);
        reset = 1'b0;

        // Loopback-style scan of 3A5C with dp on digit 2, two scans.
        for (int s = 0; s < 2; s++) begin
            show(0, 7'h39, 1'b0);
            show(1, 7'h6D, 1'b0);
            show(2, 7'h77, 1'b1);
            show(3, 7'h4F, 1'b0);
        end
        chk("loop_fv_cnt", fv_cnt, 2);
        chk("loop_digits", digits, 16'h3A5C);
        chk("loop_dp", decimal_points, 4'b0100);
        chk("loop_blank", blank, 4'b0000);
        chk("loop_pe_cnt", pe_cnt, 0);

        // Settle boundary: 3 samples not enough, 4 samples capture on edge 5.
        show(1, 7'h3F, 1'b0);
        show(2, 7'h07, 1'b0);
        show(3, 7'h7F, 1'b0);
        hold(4'b1110, 8'hF9, 3);
        hold(4'b1111, 8'hFF, 4);
        chk("short_dwell_fv_cnt", fv_cnt, 2);
        hold(4'b1110, 8'hF9, 4);
        chk("settle_edge4_fv", frame_valid, 1'b0);
        step(1);
        chk("settle_edge5_fv", frame_valid, 1'b1);
        chk("settle_digits", digits, 16'h8701);
        chk("settle_dp", decimal_points, 4'b0000);
        step(11);
        chk("settle_fv_cnt", fv_cnt, 3);

        // Bad glyph on digit 2, blank digit 1; next scan recaptures F.
        show(0, 7'h7C, 1'b0);
        show(1, 7'h00, 1'b0);
        show(2, 7'h49, 1'b0);
        show(3, 7'h5E, 1'b0);
        chk("bad_pe_cnt", pe_cnt, 1);
        chk("bad_fv_cnt", fv_cnt, 3);
        show(0, 7'h7C, 1'b0);
        show(1, 7'h00, 1'b0);
        show(2, 7'h71, 1'b0);
        show(3, 7'h5E, 1'b0);
        chk("recap_fv_cnt", fv_cnt, 4);
        chk("recap_digits", digits, 16'hDF0B);
        chk("recap_blank", blank, 4'b0010);
        chk("recap_pe_cnt", pe_cnt, 1);

        // Zero and multiple anodes low are ignored.
        hold(4'b1100, 8'hF9, 40);
        hold(4'b1111, 8'h80, 40);
        chk("ign_fv_cnt", fv_cnt, 4);
        chk("ign_pe_cnt", pe_cnt, 1);
        chk("ign_digits", digits, 16'hDF0B);
        chk("ign_stalled", stalled, 1'b1);

        // Stall clears on capture, reasserts exactly 64 cycles later.
        hold(4'b1110, 8'h80, 4);
        chk("stall_pre_cap", stalled, 1'b1);
        step(1);
        chk("stall_cleared", stalled, 1'b0);
        step(63);
        chk("stall_63", stalled, 1'b0);
        step(1);
        chk("stall_64", stalled, 1'b1);

        // Reset after three captured digits discards the partial frame.
        show(3, 7'h79, 1'b0);
        chk("stall_recap", stalled, 1'b0);
        show(0, 7'h6F, 1'b0);
        show(1, 7'h66, 1'b0);
        reset    = 1'b1;
        anodes   = 4'hF;
        segments = 8'hFF;
        step(2);
        chk("mid_rst_digits", digits, 16'h0000);
        chk("mid_rst_blank", blank, 4'h0);
        chk("mid_rst_stalled", stalled, 1'b0);
        reset = 1'b0;
        show(2, 7'h7D, 1'b1);
        show(3, 7'h5B, 1'b0);
        chk("post_rst_partial_fv", fv_cnt, 4);
        show(0, 7'h06, 1'b0);
        show(1, 7'h71, 1'b0);
        chk("post_rst_fv_cnt", fv_cnt, 5);
        chk("post_rst_digits", digits, 16'h26F1);
        chk("post_rst_dp", decimal_points, 4'b0100);
        chk("post_rst_blank", blank, 4'b0000);
        chk("final_pe_cnt", pe_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
